// File: rtl/uart_rx_fifo_if.sv
// Valid/ready word stream leaving the UART receive FIFO.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (start, DATA_BITS LSB first, optional parity, stop) feeding a valid/ready FIFO.
// Define UART_RX_PARITY_EN to add the parity bit, PARITY_ODD and a live parity_err.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 100,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx,
    uart_rx_fifo_if.master                   out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             busy,
    output logic                             frame_err,
    output logic                             overrun,
    output logic                             parity_err
);
    localparam int CNTW = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH+1);
    localparam logic [CNTW-1:0] MID      = CNTW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNTW-1:0] LAST     = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    // rx synchroniser; idles high so reset cannot fake a start bit
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
        rxs    = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= sync_d;
    end

    state_t                 state_q;
    logic [CNTW-1:0]        cnt_q;
    logic [BW-1:0]          bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   busy_q, frame_err_q;
    logic                   mid_hit, bit_hit, par_bad, push;

`ifdef UART_RX_PARITY_EN
    logic par_fail_q, parity_err_q;
    assign par_bad    = par_fail_q;
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        mid_hit = (cnt_q == MID);
        bit_hit = (cnt_q == LAST);
        push    = (state_q == STOP) && bit_hit && rxs && !par_bad;
    end

    // Frame ends at mid-stop so the next start edge can arrive half a bit early.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_fail_q   <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            cnt_q <= cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rxs) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: if (mid_hit) begin
                    cnt_q <= '0;
                    bit_q <= '0;
`ifdef UART_RX_PARITY_EN
                    par_fail_q <= 1'b0;
`endif
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (bit_hit) begin
                    cnt_q   <= '0;
                    shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                    bit_q   <= bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (bit_hit) begin
                    cnt_q      <= '0;
                    par_fail_q <= ((^shift_q) ^ rxs) != PARITY_ODD;
                    state_q    <= STOP;
                end
`endif
                STOP: if (bit_hit) begin
                    cnt_q <= '0;
                    if (!rxs) begin
                        frame_err_q <= 1'b1;
                        state_q     <= BREAK;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= par_fail_q;
`endif
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                BREAK: begin
                    cnt_q <= '0;
                    if (rxs) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign frame_err = frame_err_q;

    // Output FIFO
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overrun_q, overrun_d;
    logic                 full, pop, wr_en;

    always_comb begin
        full      = (count_q == FULL_CNT);
        pop       = (count_q != '0) && out.out_ready;
        // a full FIFO still accepts the word when the head leaves on the same edge
        wr_en     = push && (!full || pop);
        overrun_d = push && full && !pop;
        wr_d      = wr_en ? wr_q + 1'b1 : wr_q;
        rd_d      = pop   ? rd_q + 1'b1 : rd_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            if (wr_en) mem_q[wr_q] <= shift_q;
        end
    end

    assign out.out_valid = (count_q != '0);
    assign out.out_data  = (count_q != '0) ? mem_q[rd_q] : '0;
    assign fifo_count    = count_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed frames, expected words queued at issue, popped by a monitor.
module tb_uart_rx_fifo;
  localparam int CPB = 100;
  localparam int DB  = 8;
  localparam int FD  = 4;
  localparam int SS  = 2;
  localparam int CW  = $clog2(FD+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [CW-1:0] fifo_count;
  logic          busy, frame_err, overrun, parity_err;

  uart_rx_fifo_if #(.DATA_BITS(DB)) bus();

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(FD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .rx(rx), .out(bus),
    .fifo_count(fifo_count), .busy(busy), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int c0, d, fe0, ov0, pe0;
  logic [DB-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  // pulse counters
  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (overrun)    ov_cnt++;
    if (parity_err) pe_cnt++;
  end

  // scoreboard monitor: the pop happens on the next rising edge
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_word: got %0h want none", bus.out_data);
      end else begin
        check("word", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_frame(input logic [DB-1:0] dat, input logic stop_bit, input logic par_flip);
    @(posedge clk); #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < DB; i++) begin
      #1 rx = dat[i];
      repeat (CPB) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    #1 rx = (^dat) ^ par_flip;
    repeat (CPB) @(posedge clk);
`else
    if (par_flip) rx = 1'b1;
`endif
    #1 rx = stop_bit;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    idle(200);
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data",  32'(bus.out_data), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_pulses", 32'({frame_err, overrun, parity_err}), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(10);

    // 1: single word, latency of out_valid
    bus.out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    d = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        @(posedge clk); #1 c0 = cyc;
        for (int i = 0; i < 1200 && d < 0; i++) begin
          @(negedge clk);
          if (bus.out_valid) d = cyc - c0;
        end
      end
    join
    total++;
`ifdef UART_RX_PARITY_EN
    if (d < 1052 || d > 1054) begin bad++; $display("FAIL valid_latency: got %0d want 1053", d); end
`else
    if (d < 952 || d > 954) begin bad++; $display("FAIL valid_latency: got %0d want 953", d); end
`endif
    idle(20);
    check("t1_pulses", 32'(fe_cnt + ov_cnt + pe_cnt), 0);

    // 2: 20-cycle glitch is rejected
    @(posedge clk); #1 rx = 1'b0; c0 = cyc;
    repeat (20) @(posedge clk);
    #1 rx = 1'b1;
    while (cyc - c0 < 30) @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 1);
    while (cyc - c0 < 53) @(negedge clk);
    check("glitch_busy_lo", 32'(busy), 0);
    idle(20);
    check("glitch_count", 32'(fifo_count), 0);
    check("glitch_pulses", 32'(fe_cnt + ov_cnt + pe_cnt), 0);

    // 3: framing error then line held low -> one pulse, then a good frame
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(300);
    #1 rx = 1'b1;
    idle(50);
    check("ferr_once", 32'(fe_cnt - fe0), 1);
    check("ferr_count", 32'(fifo_count), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    check("ferr_ov", 32'(ov_cnt), 0);

    // 4: fill, overrun on fifth, then drain in order
    bus.out_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) begin
      if (i <= FD) exp_q.push_back(DB'(i));
      send_frame(DB'(i), 1'b1, 1'b0);
    end
    idle(5);
    check("fill_count", 32'(fifo_count), 4);
    check("fill_overrun", 32'(ov_cnt - ov0), 1);
    check("fill_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    idle(10);
    check("drain_valid", 32'(bus.out_valid), 0);
    check("drain_count", 32'(fifo_count), 0);
    check("drain_sb_empty", 32'(exp_q.size()), 0);

    // 5: full FIFO, pop on the push edge -> no overrun
    bus.out_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 0; i < FD; i++) begin
      exp_q.push_back(8'h11 + DB'(i));
      send_frame(8'h11 + DB'(i), 1'b1, 1'b0);
    end
    check("full_count", 32'(fifo_count), 4);
    exp_q.push_back(8'h66);
    fork
      send_frame(8'h66, 1'b1, 1'b0);
      begin
        @(posedge clk);
`ifdef UART_RX_PARITY_EN
        repeat (1052) @(posedge clk);
`else
        repeat (952) @(posedge clk);
`endif
        #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
      end
    join
    idle(5);
    check("simul_overrun", 32'(ov_cnt - ov0), 0);
    check("simul_count", 32'(fifo_count), 4);
    bus.out_ready = 1'b1;
    idle(10);
    check("simul_sb_empty", 32'(exp_q.size()), 0);

    // 6: reset mid-DATA discards the partial word
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        idle(400);
        rst = 1'b1;
        idle(5);
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
      end
    join
    idle(20);
    check("midrst_count", 32'(fifo_count), 0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    check("midrst_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0)), 0);

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("parity_err", 32'(pe_cnt - pe0), 1);
    check("parity_count", 32'(fifo_count), 0);
`else
    check("parity_tied", 32'(pe_cnt), 0);
`endif

    check("final_sb_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
